counter_sweep_ctrl: RTL and testbench
=====================================

Name: counter_sweep_ctrl

Overview:
- Sequencer for a `univ_bin_counter` instance.
- Drives the counter in a triangular sweep: load lo bound, count up to hi bound, count down to lo bound, repeat for a programmed number of sweeps.
- Uses a start/busy/done handshake, with hold and abort controls.
- Sits between a configuration master and a single counter datapath; owns every control pin of that counter.

Parameters:
- N, 3, counter width; passed to the counter instance.
- SW, 4, width of the sweep-count fields.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep job; sampled in IDLE only.
- abort  in  1  cancel the job; highest priority after reset.
- hold  in  1  freeze counter and FSM in place.
- lo_val  in  N  sweep lower bound.
- hi_val  in  N  sweep upper bound.
- n_sweeps  in  SW  number of full up+down sweeps.
- q  out  N  counter value (from the instance).
- up_dir  out  1  1 = counting up / heading up.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse on job completion.
- sweep_cnt  out  SW  completed sweeps in the current job.
- err  out  1  one-cycle pulse on a rejected start.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, counter q=0, up_dir=1, busy=0, done=0, err=0, sweep_cnt=0.
  - Reset mid-job abandons the job without asserting done.
- FSM states: IDLE, LOAD, UP, DOWN, FIN.
- IDLE:
  - On start, the config is valid when lo_val<hi_val and n_sweeps!=0.
  - Valid config: latch lo_r/hi_r/n_r, clear sweep_cnt, go to LOAD.
  - Invalid config: pulse err the next cycle and stay in IDLE.
  - start while not in IDLE is ignored.
- LOAD: drive load=1, d=lo_r, so q=lo_r on the next edge. busy=1 from LOAD through FIN inclusive. Go to UP.
- UP:
  - While q!=hi_r: en=1, up=1, up_dir=1.
  - When q==hi_r: en=0 (one turnaround cycle), go to DOWN, up_dir=0.
- DOWN:
  - While q!=lo_r: en=1, up=0.
  - When q==lo_r: en=0 and sweep_cnt increments.
  - If the new sweep_cnt==n_r, go to FIN; otherwise go to UP with up_dir=1.
- FIN: done=1 for this single cycle, busy=0 next cycle, return to IDLE. q holds lo_r.
- Timing:
  - One counter step per cycle, plus one turnaround cycle at each bound.
  - Example, lo=1, hi=4, n=1, start seen at edge 0:
    - LOAD at cycle 1.
    - q=1,2,3,4 at cycles 2–5.
    - DOWN at cycle 6; q=3,2,1 at cycles 7–9.
    - FIN with done=1 at cycle 10.
- hold=1 (in UP/DOWN/LOAD):
  - en=0, load=0, state and sweep_cnt frozen.
  - Bound comparisons are not acted on.
  - hold is ignored in IDLE and FIN.
- abort=1 in any non-IDLE state:
  - syn_clr=1, so q=0 next cycle.
  - Go to IDLE; busy=0 next cycle; done not pulsed; sweep_cnt holds its last value.
- Priority: reset > abort > hold > normal.
- The counter never wraps: turning at hi_r/lo_r guarantees q stays within [lo_r, hi_r]. The counter's max_tick/min_tick are unused in the base build.
- hi_val=2^N-1 and lo_val=0 are legal.

Optional Feature:
- Macro: SWEEP_CONT_EN.
- Defined:
  - n_sweeps==0 at start is accepted and means continuous sweeping until abort.
  - sweep_cnt wraps modulo 2^SW.
  - FIN is never reached in this mode.
- Undefined: n_sweeps==0 is rejected with an err pulse.

Decomposition:
- Package counter_sweep_pkg:
  - state enum (IDLE, LOAD, UP, DOWN, FIN).
  - default width constants for N and SW.
- One sub-module: univ_bin_counter, instantiated with N. This block only generates syn_clr/load/en/up/d.

Test Plan:
- lo=1, hi=4, n=1, start pulse -> q sequence 1,2,3,4,4,3,2,1; done=1 exactly at cycle 10; sweep_cnt=1; busy low after.
- lo=0, hi=7, n=2 (N=3) -> two full triangles with no wrap (q never 0→7 or 7→0 in a step); done once; sweep_cnt=2.
- lo=5, hi=5 start -> err=1 one cycle, busy stays 0, q unchanged. n_sweeps=0 -> err (macro undefined) or continuous run (SWEEP_CONT_EN).
- hold=1 for 3 cycles while q=3 going up -> q stays 3 for 3 cycles, then resumes 4; done timing shifts by exactly 3 cycles.
- abort at q=2 in DOWN -> q=0 next cycle, busy=0, no done; a new start (lo=2, hi=3, n=1) completes normally.
- reset asserted mid-UP -> all outputs to reset values on the next edge; a start in the same cycle as reset is ignored.

Source files
------------

// File: rtl/counter_sweep_pkg.sv
// Shared types and default widths for the counter sweep sequencer.
// Build option SWEEP_CONT_EN is consumed by counter_sweep_ctrl, not here.
package counter_sweep_pkg;

   localparam int N_DEF  = 3;
   localparam int SW_DEF = 4;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      UP,
      DOWN,
      FIN
   } state_t;

endpackage

// File: rtl/univ_bin_counter.sv
// Universal binary up/down counter: sync clear, parallel load, enable, direction.
// Priority: reset > syn_clr > load > en.
module univ_bin_counter #(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         syn_clr,
   input  logic         load,
   input  logic         en,
   input  logic         up,
   input  logic [N-1:0] d,
   output logic         max_tick,
   output logic         min_tick,
   output logic [N-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset)
         q <= '0;
      else if (syn_clr)
         q <= '0;
      else if (load)
         q <= d;
      else if (en)
         q <= up ? q + N'(1) : q - N'(1);
   end

   assign max_tick = (q == '1);
   assign min_tick = (q == '0);

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Triangular sweep sequencer driving one univ_bin_counter (lo -> hi -> lo, n times).
// Build option: define SWEEP_CONT_EN to accept n_sweeps==0 as "sweep until abort".
//
// state | meaning
// IDLE  | waiting for start; config checked here
// LOAD  | counter loaded with lo bound
// UP    | stepping up; one turnaround cycle at hi bound
// DOWN  | stepping down; sweep counted at lo bound
// FIN   | done pulse, back to IDLE
module counter_sweep_ctrl
   import counter_sweep_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int SW = SW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          abort,
   input  logic          hold,
   input  logic [N-1:0]  lo_val,
   input  logic [N-1:0]  hi_val,
   input  logic [SW-1:0] n_sweeps,
   output logic [N-1:0]  q,
   output logic          up_dir,
   output logic          busy,
   output logic          done,
   output logic [SW-1:0] sweep_cnt,
   output logic          err
);

   state_t        state, state_n;
   logic [N-1:0]  lo_r, hi_r;
   logic [SW-1:0] n_r;
   logic [SW-1:0] sweep_nxt;
   logic          cfg_ok, cont;
   logic          accept, reject, inc, to_down, to_up;
   logic          cnt_clr, cnt_load, cnt_en, cnt_up;
   logic          max_tick, min_tick;

`ifdef SWEEP_CONT_EN
   assign cfg_ok = (lo_val < hi_val);
   assign cont   = (n_r == '0);
`else
   assign cfg_ok = (lo_val < hi_val) && (n_sweeps != '0);
   assign cont   = 1'b0;
`endif

   assign sweep_nxt = sweep_cnt + SW'(1);

   always_comb begin
      state_n  = state;
      cnt_clr  = 1'b0;
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
      cnt_up   = 1'b0;
      accept   = 1'b0;
      reject   = 1'b0;
      inc      = 1'b0;
      to_down  = 1'b0;
      to_up    = 1'b0;
      if (state != IDLE && abort) begin
         cnt_clr = 1'b1;
         state_n = IDLE;
      end else if (hold && (state == LOAD || state == UP || state == DOWN)) begin
         state_n = state;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (cfg_ok) begin
                     accept  = 1'b1;
                     state_n = LOAD;
                  end else begin
                     reject = 1'b1;
                  end
               end
            end
            LOAD: begin
               cnt_load = 1'b1;
               state_n  = UP;
            end
            UP: begin
               if (q != hi_r) begin
                  cnt_en = 1'b1;
                  cnt_up = 1'b1;
               end else begin
                  to_down = 1'b1;
                  state_n = DOWN;
               end
            end
            DOWN: begin
               if (q != lo_r) begin
                  cnt_en = 1'b1;
               end else begin
                  inc = 1'b1;
                  if (!cont && sweep_nxt == n_r) begin
                     state_n = FIN;
                  end else begin
                     to_up   = 1'b1;
                     state_n = UP;
                  end
               end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         lo_r      <= '0;
         hi_r      <= '0;
         n_r       <= '0;
         sweep_cnt <= '0;
         up_dir    <= 1'b1;
         err       <= 1'b0;
      end else begin
         state <= state_n;
         err   <= reject;
         if (accept) begin
            lo_r      <= lo_val;
            hi_r      <= hi_val;
            n_r       <= n_sweeps;
            sweep_cnt <= '0;
            up_dir    <= 1'b1;
         end
         if (inc)
            sweep_cnt <= sweep_nxt;
         if (to_down)
            up_dir <= 1'b0;
         if (to_up)
            up_dir <= 1'b1;
      end
   end

   assign busy = (state != IDLE);
   // An abort landing on FIN cancels the completion pulse as well.
   assign done = (state == FIN) && !abort;

   univ_bin_counter #(.N(N)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .syn_clr  (cnt_clr),
      .load     (cnt_load),
      .en       (cnt_en),
      .up       (cnt_up),
      .d        (lo_r),
      .max_tick (max_tick),
      .min_tick (min_tick),
      .q        (q)
   );

   // Turning at the bounds means the counter is never stepped past its range.
   no_wrap_a: assert property (@(posedge clk) disable iff (reset)
      !(cnt_en && ((cnt_up && max_tick) || (!cnt_up && min_tick))));

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Self-checking bench for counter_sweep_ctrl: each job is expanded into the
// expected per-cycle trace (triangle of q values), replayed with random holds/aborts.
module tb_counter_sweep_ctrl;

   localparam int N  = 3;
   localparam int SW = 4;

   logic          clk, reset, start, abort, hold;
   logic [N-1:0]  lo_val, hi_val, q;
   logic [SW-1:0] n_sweeps, sweep_cnt;
   logic          up_dir, busy, done, err;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state carried between jobs
   int q_model   = 0;
   int up_model  = 1;
   int cnt_model = 0;

   typedef struct {
      int q;
      int busy;
      int done;
      int up;
      int cnt;
      int holdable;
   } exp_t;

   counter_sweep_ctrl #(.N(N), .SW(SW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .hold      (hold),
      .lo_val    (lo_val),
      .hi_val    (hi_val),
      .n_sweeps  (n_sweeps),
      .q         (q),
      .up_dir    (up_dir),
      .busy      (busy),
      .done      (done),
      .sweep_cnt (sweep_cnt),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t mk(int qv, int b, int d, int u, int c, int h);
      exp_t e;
      e.q = qv; e.busy = b; e.done = d; e.up = u; e.cnt = c; e.holdable = h;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_entry(input exp_t e);
      check("q",         int'(q),         e.q);
      check("busy",      int'(busy),      e.busy);
      check("done",      int'(done),      e.done);
      check("up_dir",    int'(up_dir),    e.up);
      check("sweep_cnt", int'(sweep_cnt), e.cnt);
      check("err",       int'(err),       0);
   endtask

   // abort_at: -1 none, -2 random index, otherwise trace index to abort at
   task automatic run_job(input int lo, input int hi, input int n,
                          input int hold_pct, input int hold_idx, input int hold_len,
                          input int abort_at);
      exp_t tr[$];
      exp_t e;
      int   idx, held, guard, ab;
      bit   h;
      tr.push_back(mk(q_model, 1, 0, 1, 0, 1));
      for (int k = 0; k < n; k++) begin
         for (int v = lo; v <= hi; v++) tr.push_back(mk(v, 1, 0, 1, k, 1));
         for (int v = hi; v >= lo; v--) tr.push_back(mk(v, 1, 0, 0, k, 1));
      end
      tr.push_back(mk(lo, 1, 1, 0, n, 0));
      ab = abort_at;
      if (ab == -2) ab = $urandom_range(0, tr.size() - 2);

      lo_val   = N'(lo);
      hi_val   = N'(hi);
      n_sweeps = SW'(n);
      start    = 1'b1;
      tick();
      start = 1'b0;
      idx   = 0;
      held  = 0;
      guard = 0;
      while (idx < tr.size()) begin
         e = tr[idx];
         check_entry(e);
         if (idx == ab) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check("abort_q",    int'(q),         0);
            check("abort_busy", int'(busy),      0);
            check("abort_done", int'(done),      0);
            check("abort_cnt",  int'(sweep_cnt), e.cnt);
            check("abort_up",   int'(up_dir),    e.up);
            q_model = 0; up_model = e.up; cnt_model = e.cnt;
            return;
         end
         h = 1'b0;
         if (e.holdable != 0) begin
            if (idx == hold_idx && held < hold_len) begin
               h = 1'b1;
               held++;
            end else if ($urandom_range(0, 99) < hold_pct) begin
               h = 1'b1;
            end
         end
         hold = h;
         tick();
         hold = 1'b0;
         if (!h) idx++;
         guard++;
         if (guard > 2000) begin
            check("job_cycle_budget", guard, 2000);
            return;
         end
      end
      check("idle_busy", int'(busy),      0);
      check("idle_done", int'(done),      0);
      check("idle_q",    int'(q),         lo);
      check("idle_cnt",  int'(sweep_cnt), n);
      check("idle_up",   int'(up_dir),    0);
      q_model = lo; up_model = 0; cnt_model = n;
   endtask

   task automatic bad_start(input int lo, input int hi, input int n);
      lo_val   = N'(lo);
      hi_val   = N'(hi);
      n_sweeps = SW'(n);
      start    = 1'b1;
      tick();
      start = 1'b0;
      check("rej_err",  int'(err),       1);
      check("rej_busy", int'(busy),      0);
      check("rej_q",    int'(q),         q_model);
      check("rej_cnt",  int'(sweep_cnt), cnt_model);
      check("rej_up",   int'(up_dir),    up_model);
      tick();
      check("rej_err_clear", int'(err),  0);
      check("rej_busy2",     int'(busy), 0);
   endtask

   initial begin
      int lo, hi, n;
      reset = 1'b1; start = 1'b0; abort = 1'b0; hold = 1'b0;
      lo_val = '0; hi_val = '0; n_sweeps = '0;
      tick();
      tick();
      check("rst_q",    int'(q),         0);
      check("rst_busy", int'(busy),      0);
      check("rst_done", int'(done),      0);
      check("rst_err",  int'(err),       0);
      check("rst_cnt",  int'(sweep_cnt), 0);
      check("rst_up",   int'(up_dir),    1);
      reset = 1'b0;
      tick();

      run_job(1, 4, 1, 0, -1, 0, -1);
      run_job(0, 7, 2, 0, -1, 0, -1);
      // hold 3 cycles while q=3 heading up (trace index 3)
      run_job(1, 4, 1, 0, 3, 3, -1);
      // abort at q=2 heading down (trace index 7), then a clean job
      run_job(1, 4, 1, 0, -1, 0, 7);
      run_job(2, 3, 1, 0, -1, 0, -1);

      bad_start(5, 5, 1);
      bad_start(6, 2, 2);
`ifndef SWEEP_CONT_EN
      bad_start(1, 4, 0);
`endif

      repeat (10) begin
         lo = $urandom_range(0, 6);
         hi = $urandom_range(lo + 1, 7);
         n  = $urandom_range(1, 3);
         run_job(lo, hi, n, 20, -1, 0, ($urandom_range(0, 3) == 0) ? -2 : -1);
      end

      // reset mid-UP, with a valid start in the same cycle
      lo_val = 3'd0; hi_val = 3'd6; n_sweeps = 4'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      check("pre_rst_busy", int'(busy), 1);
      reset = 1'b1;
      start = 1'b1;
      tick();
      check("midrst_q",    int'(q),         0);
      check("midrst_busy", int'(busy),      0);
      check("midrst_done", int'(done),      0);
      check("midrst_err",  int'(err),       0);
      check("midrst_cnt",  int'(sweep_cnt), 0);
      check("midrst_up",   int'(up_dir),    1);
      reset = 1'b0;
      start = 1'b0;
      tick();
      check("post_rst_busy", int'(busy), 0);
      check("post_rst_q",    int'(q),    0);
      q_model = 0; up_model = 1; cnt_model = 0;
      run_job(1, 2, 1, 0, -1, 0, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
